// File: rtl/banco_pkg.sv
// Shared constants and small helpers for the parametrised MIPS register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package banco_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // True when the address selects the hardwired-zero register and that
    // feature is enabled.
    function automatic logic is_zero_reg(input int unsigned addr, input logic zero_en);
        return zero_en && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/banco_scoreboard.sv
// Busy scoreboard: one bit per register, set by reservations, cleared by port-1 completions.
// Latency: busy updates on the rising edge; per-port lookup and AnyBusy are combinational.
// Backpressure: none; the hazard unit consumes rd_busy/any_busy to stall issue.
//
// Ports: clk, rst_n (async active-low); rd_addr packed NUM_READ addresses -> rd_busy;
//        rsv_en/rsv_reg reserve; clr_en/clr_reg port-1 completion clear; any_busy = OR of busy.
module banco_scoreboard
    import banco_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ-1:0]        rd_busy,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_reg,
    input  logic                       clr_en,
    input  logic [ADDR_W-1:0]          clr_reg,
    output logic                       any_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clear first, then reserve, so a same-cycle reserve of a completing
    // register keeps it busy for the newly issued producer. Addresses beyond
    // DEPTH never match any index and are therefore ignored.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (clr_en && (clr_reg == ADDR_W'(r))) busy_d[r] = 1'b0;
            if (rsv_en && (rsv_reg == ADDR_W'(r))) busy_d[r] = 1'b1;
        end
        if (ZERO_REG != 0) busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) rd_busy[i] = busy_q[r];
            end
            // A completing port-1 write releases the reader in the same cycle,
            // unless a new producer reserves the register at the same time.
            if ((BYPASS != 0) && clr_en && (clr_reg == rd_addr[i*ADDR_W +: ADDR_W]) &&
                !(rsv_en && (rsv_reg == rd_addr[i*ADDR_W +: ADDR_W])))
                rd_busy[i] = 1'b0;
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised MIPS register bank: NUM_READ async read ports, two sync write ports, busy scoreboard.
// Latency: reads combinational (zero cycles); writes visible after the rising edge (or same cycle with BYPASS).
// Backpressure: none; stalls are signalled through ReadBusy/AnyBusy.
//
// Ports: clk, rst_n; ReadReg/ReadData/ReadBusy packed per read port; RegWrite0/WriteReg0/WriteData0
//        normal writeback; RegWrite1/WriteReg1/WriteData1 long-latency completion (clears busy);
//        RsvEn/RsvReg mark a register busy; AnyBusy = any register busy.
module banco_registros_param
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_READ*ADDR_W-1:0] ReadReg,
    output logic [NUM_READ*DATA_W-1:0] ReadData,
    output logic [NUM_READ-1:0]        ReadBusy,
    input  logic                       RegWrite0,
    input  logic [ADDR_W-1:0]          WriteReg0,
    input  logic [DATA_W-1:0]          WriteData0,
    input  logic                       RegWrite1,
    input  logic [ADDR_W-1:0]          WriteReg1,
    input  logic [DATA_W-1:0]          WriteData1,
    input  logic                       RsvEn,
    input  logic [ADDR_W-1:0]          RsvReg,
    output logic                       AnyBusy
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Port 1 is applied before port 0 so port 0 wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (RegWrite1 && (WriteReg1 == ADDR_W'(r))) regs_d[r] = WriteData1;
            if (RegWrite0 && (WriteReg0 == ADDR_W'(r))) regs_d[r] = WriteData0;
        end
        if (ZERO_REG != 0) regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] rd_val;
        logic              in_rng;

        assign addr = ReadReg[i*ADDR_W +: ADDR_W];

        always_comb begin
            stored = '0;
            in_rng = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                if (addr == ADDR_W'(r)) begin
                    stored = regs_q[r];
                    in_rng = 1'b1;
                end
            end
            rd_val = stored;
            // Forwarding is suppressed under reset so reads stay zero while rst_n is low.
            if ((BYPASS != 0) && rst_n && in_rng) begin
                if (RegWrite0 && (WriteReg0 == addr))      rd_val = WriteData0;
                else if (RegWrite1 && (WriteReg1 == addr)) rd_val = WriteData1;
            end
            if (is_zero_reg(int'(addr), ZERO_REG != 0)) rd_val = '0;
        end

        assign ReadData[i*DATA_W +: DATA_W] = rd_val;
    end

    banco_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (ReadReg),
        .rd_busy  (ReadBusy),
        .rsv_en   (RsvEn),
        .rsv_reg  (RsvReg),
        .clr_en   (RegWrite1),
        .clr_reg  (WriteReg1),
        .any_busy (AnyBusy)
    );

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param using three configurations sharing write stimulus:
// A: 3 read ports, BYPASS=1, DEPTH=32; B: 2 read ports, BYPASS=0; C: 1 read port, DEPTH=16.
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, rsv;
    logic [4:0]  wa0, wa1, rr;
    logic [31:0] wd0, wd1;

    logic [14:0] rd_a;
    logic [95:0] rdat_a;
    logic [2:0]  rbusy_a;
    logic        anyb_a;
    logic [9:0]  rd_b;
    logic [63:0] rdat_b;
    logic [1:0]  rbusy_b;
    logic        anyb_b;
    logic [4:0]  rd_c;
    logic [31:0] rdat_c;
    logic [0:0]  rbusy_c;
    logic        anyb_c;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    banco_registros_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_READ(3), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ReadReg(rd_a), .ReadData(rdat_a), .ReadBusy(rbusy_a),
        .RegWrite0(we0), .WriteReg0(wa0), .WriteData0(wd0),
        .RegWrite1(we1), .WriteReg1(wa1), .WriteData1(wd1),
        .RsvEn(rsv), .RsvReg(rr), .AnyBusy(anyb_a));

    banco_registros_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_READ(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ReadReg(rd_b), .ReadData(rdat_b), .ReadBusy(rbusy_b),
        .RegWrite0(we0), .WriteReg0(wa0), .WriteData0(wd0),
        .RegWrite1(we1), .WriteReg1(wa1), .WriteData1(wd1),
        .RsvEn(rsv), .RsvReg(rr), .AnyBusy(anyb_b));

    banco_registros_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .NUM_READ(1), .BYPASS(1), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .ReadReg(rd_c), .ReadData(rdat_c), .ReadBusy(rbusy_c),
        .RegWrite0(we0), .WriteReg0(wa0), .WriteData0(wd0),
        .RegWrite1(we1), .WriteReg1(wa1), .WriteData1(wd1),
        .RsvEn(rsv), .RsvReg(rr), .AnyBusy(anyb_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; rsv = 1'b0;
        wa0 = '0;   wa1 = '0;   rr  = '0;
        wd0 = '0;   wd1 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rd_a = {3{5'd5}}; rd_b = {2{5'd5}}; rd_c = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdat_a[31:0] !== 32'h0) $display("FAIL reset_init_data got %h want %h", rdat_a[31:0], 32'h0); else passed++;
        total++; if (anyb_a !== 1'b0) $display("FAIL reset_init_anybusy got %b want 0", anyb_a); else passed++;
        rst_n = 1'b1;
        tick();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        rsv = 1'b1; rr = 5'd6;
        tick();
        idle();
        #1;
        total++; if (rdat_a[31:0] !== 32'hDEADBEEF) $display("FAIL reset_pre_data got %h want %h", rdat_a[31:0], 32'hDEADBEEF); else passed++;
        total++; if (anyb_a !== 1'b1) $display("FAIL reset_pre_anybusy got %b want 1", anyb_a); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (rdat_a[31:0] !== 32'h0) $display("FAIL reset_async_data got %h want %h", rdat_a[31:0], 32'h0); else passed++;
        total++; if (anyb_a !== 1'b0) $display("FAIL reset_async_anybusy got %b want 0", anyb_a); else passed++;
        total++; if (rbusy_a !== 3'b000) $display("FAIL reset_async_readbusy got %b want 000", rbusy_a); else passed++;
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678;
        tick();
        idle();
        rd_a = {3{5'd7}}; rd_b = {2{5'd7}};
        #1;
        for (int p = 0; p < 3; p++) begin
            total++;
            if (rdat_a[p*32 +: 32] !== 32'h12345678)
                $display("FAIL basic_read_port%0d got %h want %h", p, rdat_a[p*32 +: 32], 32'h12345678);
            else passed++;
        end
        total++; if (rdat_b[63:32] !== 32'h12345678) $display("FAIL basic_read_b got %h want %h", rdat_b[63:32], 32'h12345678); else passed++;
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        rd_a = {5'd7, 5'd0, 5'd0};
        #1;
        total++; if (rdat_a[31:0] !== 32'h0) $display("FAIL r0_bypass got %h want %h", rdat_a[31:0], 32'h0); else passed++;
        tick();
        idle();
        #1;
        total++; if (rdat_a[63:32] !== 32'h0) $display("FAIL r0_after got %h want %h", rdat_a[63:32], 32'h0); else passed++;
        total++; if (rdat_a[95:64] !== 32'h12345678) $display("FAIL r7_unchanged got %h want %h", rdat_a[95:64], 32'h12345678); else passed++;
    endtask

    task automatic test_collision();
        rsv = 1'b1; rr = 5'd9;
        tick();
        idle();
        rd_a = {3{5'd9}}; rd_b = {2{5'd9}};
        #1;
        total++; if (rbusy_a[0] !== 1'b1) $display("FAIL coll_reserved got %b want 1", rbusy_a[0]); else passed++;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hAAAA0000;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h5555FFFF;
        #1;
        total++; if (rdat_a[31:0] !== 32'hAAAA0000) $display("FAIL coll_bypass got %h want %h", rdat_a[31:0], 32'hAAAA0000); else passed++;
        total++; if (rbusy_a[1] !== 1'b0) $display("FAIL coll_busy_incycle got %b want 0", rbusy_a[1]); else passed++;
        tick();
        idle();
        #1;
        total++; if (rdat_a[31:0] !== 32'hAAAA0000) $display("FAIL coll_data got %h want %h", rdat_a[31:0], 32'hAAAA0000); else passed++;
        total++; if (rdat_b[31:0] !== 32'hAAAA0000) $display("FAIL coll_data_b got %h want %h", rdat_b[31:0], 32'hAAAA0000); else passed++;
        total++; if (rbusy_a[2] !== 1'b0) $display("FAIL coll_busy got %b want 0", rbusy_a[2]); else passed++;
    endtask

    task automatic test_bypass();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1;
        tick();
        idle();
        rd_a = {3{5'd3}}; rd_b = {2{5'd3}};
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h2;
        #1;
        total++; if (rdat_a[31:0] !== 32'h2) $display("FAIL byp1_incycle got %h want %h", rdat_a[31:0], 32'h2); else passed++;
        total++; if (rdat_b[31:0] !== 32'h1) $display("FAIL byp0_incycle got %h want %h", rdat_b[31:0], 32'h1); else passed++;
        tick();
        idle();
        #1;
        total++; if (rdat_b[31:0] !== 32'h2) $display("FAIL byp0_after got %h want %h", rdat_b[31:0], 32'h2); else passed++;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5;
        #1;
        total++; if (rdat_a[63:32] !== 32'h5) $display("FAIL byp1_port1 got %h want %h", rdat_a[63:32], 32'h5); else passed++;
        total++; if (rdat_b[63:32] !== 32'h2) $display("FAIL byp0_port1 got %h want %h", rdat_b[63:32], 32'h2); else passed++;
        tick();
        idle();
        #1;
        total++; if (rdat_a[95:64] !== 32'h5) $display("FAIL byp_port1_after got %h want %h", rdat_a[95:64], 32'h5); else passed++;
    endtask

    task automatic test_scoreboard();
        rsv = 1'b1; rr = 5'd12;
        tick();
        idle();
        rd_a = {3{5'd12}}; rd_b = {2{5'd12}};
        #1;
        total++; if (rbusy_a[0] !== 1'b1) $display("FAIL sb_rsv_busy got %b want 1", rbusy_a[0]); else passed++;
        total++; if (anyb_a !== 1'b1) $display("FAIL sb_rsv_any got %b want 1", anyb_a); else passed++;
        total++; if (rbusy_b[0] !== 1'b1) $display("FAIL sb_rsv_busy_b got %b want 1", rbusy_b[0]); else passed++;
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h77;
        #1;
        total++; if (rbusy_a[0] !== 1'b0) $display("FAIL sb_clr_incycle got %b want 0", rbusy_a[0]); else passed++;
        total++; if (rbusy_b[0] !== 1'b1) $display("FAIL sb_clr_incycle_b got %b want 1", rbusy_b[0]); else passed++;
        tick();
        idle();
        #1;
        total++; if (rbusy_a[1] !== 1'b0) $display("FAIL sb_clr_busy got %b want 0", rbusy_a[1]); else passed++;
        total++; if (rbusy_b[1] !== 1'b0) $display("FAIL sb_clr_busy_b got %b want 0", rbusy_b[1]); else passed++;
        total++; if (rdat_a[31:0] !== 32'h77) $display("FAIL sb_clr_data got %h want %h", rdat_a[31:0], 32'h77); else passed++;
        total++; if (anyb_a !== 1'b0) $display("FAIL sb_clr_any got %b want 0", anyb_a); else passed++;
        rsv = 1'b1; rr = 5'd12;
        tick();
        rsv = 1'b1; rr = 5'd12;
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h88;
        #1;
        total++; if (rbusy_a[0] !== 1'b1) $display("FAIL sb_both_incycle got %b want 1", rbusy_a[0]); else passed++;
        tick();
        idle();
        #1;
        total++; if (rbusy_a[2] !== 1'b1) $display("FAIL sb_both_busy got %b want 1", rbusy_a[2]); else passed++;
        total++; if (rdat_a[63:32] !== 32'h88) $display("FAIL sb_both_data got %h want %h", rdat_a[63:32], 32'h88); else passed++;
        rsv = 1'b1; rr = 5'd12;
        tick();
        idle();
        #1;
        total++; if (rbusy_a[0] !== 1'b1) $display("FAIL sb_rsv_again got %b want 1", rbusy_a[0]); else passed++;
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h99;
        tick();
        idle();
        rsv = 1'b1; rr = 5'd0;
        tick();
        idle();
        rd_a = {3{5'd0}};
        #1;
        total++; if (rbusy_a[0] !== 1'b0) $display("FAIL sb_r0_busy got %b want 0", rbusy_a[0]); else passed++;
        total++; if (anyb_a !== 1'b0) $display("FAIL sb_r0_any got %b want 0", anyb_a); else passed++;
    endtask

    task automatic test_out_of_range();
        rd_c = 5'd20;
        rd_a = {3{5'd20}};
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h9;
        rsv = 1'b1; rr = 5'd20;
        #1;
        total++; if (rdat_c !== 32'h0) $display("FAIL oor_incycle got %h want %h", rdat_c, 32'h0); else passed++;
        tick();
        idle();
        #1;
        total++; if (rdat_c !== 32'h0) $display("FAIL oor_data got %h want %h", rdat_c, 32'h0); else passed++;
        total++; if (rbusy_c !== 1'b0) $display("FAIL oor_busy got %b want 0", rbusy_c); else passed++;
        total++; if (anyb_c !== 1'b0) $display("FAIL oor_any got %b want 0", anyb_c); else passed++;
        total++; if (rdat_a[31:0] !== 32'h9) $display("FAIL oor_wide_data got %h want %h", rdat_a[31:0], 32'h9); else passed++;
        total++; if (rbusy_a[0] !== 1'b1) $display("FAIL oor_wide_busy got %b want 1", rbusy_a[0]); else passed++;
        rd_c = 5'd4;
        #1;
        total++; if (rdat_c !== 32'h0) $display("FAIL oor_alias got %h want %h", rdat_c, 32'h0); else passed++;
        rd_c = 5'd7;
        #1;
        total++; if (rdat_c !== 32'h12345678) $display("FAIL oor_r7_kept got %h want %h", rdat_c, 32'h12345678); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_out_of_range();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
